// File: rtl/seq_multiplier_32.sv
// Sequential unsigned 32x32->64 shift-and-add multiplier.
// One add-and-shift per clock through a ripple-carry Adder_32.

module Adder_32 (
    input  logic [31:0] A_in32,
    input  logic [31:0] B_in32,
    input  logic        Carry_in,
    output logic [31:0] Sum_out32,
    output logic        Carry_out
);

    logic [32:0] w_carry;

    assign w_carry[0] = Carry_in;

    genvar i;
    generate
        for (i = 0; i < 32; i++) begin : g_fa
            logic w_p;
            assign w_p            = A_in32[i] ^ B_in32[i];
            assign Sum_out32[i]   = w_p ^ w_carry[i];
            assign w_carry[i + 1] = (A_in32[i] & B_in32[i])
                                  | (w_carry[i] & w_p);
        end
    endgenerate

    assign Carry_out = w_carry[32];

endmodule

module seq_multiplier_32 (
    input  logic        Clk_in,
    input  logic        Reset_n_in,
    input  logic        Start_in,
    input  logic [31:0] Multiplicand_in32,
    input  logic [31:0] Multiplier_in32,
    output logic [63:0] Product_out64,
    output logic        Busy_out,
    output logic        Done_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_mcand;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [4:0]  r_cnt;
    logic [63:0] r_product;

    logic        w_accept;
    logic        w_step;
    logic        w_last;

    logic [31:0] w_addend;
    logic [31:0] w_sum;
    logic        w_carry;

    // The adder carry is the bit above hi; after the right shift it lands
    // in hi[31], so the stored carry bit is always zero and needs no flop.
    assign w_addend = r_lo[0] ? r_mcand : 32'h0;

    Adder_32 u_adder (
        .A_in32    (r_hi),
        .B_in32    (w_addend),
        .Carry_in  (1'b0),
        .Sum_out32 (w_sum),
        .Carry_out (w_carry)
    );

    // State register
    always_ff @(posedge Clk_in or negedge Reset_n_in) begin
        if (!Reset_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control decode
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (Start_in) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_cnt == 5'd31) begin
                    w_last       = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (Start_in) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand capture and add-and-shift datapath
    always_ff @(posedge Clk_in or negedge Reset_n_in) begin
        if (!Reset_n_in) begin
            r_mcand <= 32'h0;
            r_hi    <= 32'h0;
            r_lo    <= 32'h0;
            r_cnt   <= 5'd0;
        end else if (w_accept) begin
            r_mcand <= Multiplicand_in32;
            r_hi    <= 32'h0;
            r_lo    <= Multiplier_in32;
            r_cnt   <= 5'd0;
        end else if (w_step) begin
            r_hi    <= {w_carry, w_sum[31:1]};
            r_lo    <= {w_sum[0], r_lo[31:1]};
            r_cnt   <= r_cnt + 5'd1;
        end
    end

    // Result register: loaded from the post-shift value on the last step
    always_ff @(posedge Clk_in or negedge Reset_n_in) begin
        if (!Reset_n_in) begin
            r_product <= 64'h0;
        end else if (w_last) begin
            r_product <= {w_carry, w_sum, r_lo[31:1]};
        end
    end

    assign Product_out64 = r_product;
    assign Busy_out      = (r_state == S_RUN);
    assign Done_out      = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_multiplier_32.sv
// Self-checking bench for seq_multiplier_32.
// Random and directed operands checked against a plain A*B model.

module tb_seq_multiplier_32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [63:0] product;
    logic        busy;
    logic        done;

    int          checks;
    int          failures;
    logic [63:0] last_exp;

    seq_multiplier_32 dut (
        .Clk_in            (clk),
        .Reset_n_in        (rst_n),
        .Start_in          (start),
        .Multiplicand_in32 (mcand),
        .Multiplier_in32   (mplier),
        .Product_out64     (product),
        .Busy_out          (busy),
        .Done_out          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Waits up to 40 cycles for Done; returns cycles waited (99 = timeout).
    // Also reports whether the product changed before Done.
    task automatic wait_done(output int lat, output logic early_chg,
                             input logic [63:0] held);
        lat       = 99;
        early_chg = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (product !== held) early_chg = 1'b1;
            if (!busy) early_chg = 1'b1;
        end
    endtask

    task automatic do_mul(input string tag, input logic [31:0] a,
                          input logic [31:0] b);
        int          lat;
        logic        chg;
        logic [63:0] exp;
        exp    = model(a, b);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        @(negedge clk);
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(lat, chg, last_exp);
        check({tag, "_lat"}, 64'(lat), 64'd32);
        check({tag, "_held"}, 64'(chg), 64'd0);
        check({tag, "_prod"}, product, exp);
        check({tag, "_nbusy"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_dfall"}, 64'(done), 64'd0);
        check({tag, "_hold"}, product, exp);
        last_exp = exp;
    endtask

    initial begin
        int          lat;
        logic        chg;
        int          dcount;
        logic [31:0] ra;
        logic [31:0] rb;

        checks   = 0;
        failures = 0;
        last_exp = 64'h0;
        rst_n    = 1'b0;
        start    = 1'b0;
        mcand    = 32'h0;
        mplier   = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_prod", product, 64'h0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_mul("3x5", 32'd3, 32'd5);
        do_mul("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_mul("ax0", 32'h1234_5678, 32'h0);
        do_mul("0xb", 32'h0, 32'hDEAD_BEEF);
        do_mul("1x1", 32'd1, 32'd1);
        do_mul("msb", 32'h8000_0000, 32'h8000_0001);

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_mul($sformatf("rnd%0d", i), ra, rb);
        end

        // Start pulse and operand noise during RUN are ignored
        start  = 1'b1;
        mcand  = 32'd7;
        mplier = 32'd9;
        @(negedge clk);
        start = 1'b0;
        lat   = 99;
        for (int k = 1; k <= 40; k++) begin
            start  = (k == 10);
            mcand  = (k == 10) ? 32'd1 : $urandom;
            mplier = (k == 10) ? 32'd1 : $urandom;
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        check("ign_lat", 64'(lat), 64'd32);
        check("ign_prod", product, 64'd63);
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("ign_nodone", 64'(dcount), 64'd0);
        check("ign_hold", product, 64'd63);
        last_exp = 64'd63;

        // Back-to-back: Start held through DONE
        start  = 1'b1;
        mcand  = 32'd2;
        mplier = 32'd3;
        @(negedge clk);
        mcand  = 32'd10;
        mplier = 32'd10;
        wait_done(lat, chg, last_exp);
        check("b2b_lat1", 64'(lat), 64'd32);
        check("b2b_prod1", product, 64'd6);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_done0", 64'(done), 64'd0);
        wait_done(lat, chg, 64'd6);
        check("b2b_lat2", 64'(lat), 64'd32);
        check("b2b_held", 64'(chg), 64'd0);
        check("b2b_prod2", product, 64'd100);
        @(negedge clk);
        last_exp = 64'd100;

        // Asynchronous reset in the middle of an operation
        start  = 1'b1;
        mcand  = 32'h8000_0000;
        mplier = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_prod", product, 64'h0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("arst_quiet", 64'(dcount), 64'd0);
        rst_n    = 1'b1;
        last_exp = 64'h0;
        @(negedge clk);
        do_mul("post_rst", 32'h8000_0000, 32'd2);
        check("post_rst_val", product, 64'h0000_0001_0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_multiplier_32.md
# seq_multiplier_32

Sequential unsigned 32×32→64 shift-and-add multiplier for the calculation datapath. It drives one `Adder_32` instance with the running upper partial product and the multiplicand, then consumes the sum and carry on every iteration. It performs one add-and-shift per clock under a start/busy/done handshake and presents a held 64-bit product to downstream logic.

## Interface
- No parameters. The datapath width is fixed at 32 bits by the `Adder_32` instance.
- `Clk_in` in 1: single clock; all state updates on the rising edge.
- `Reset_n_in` in 1: asynchronous, active-low reset.
- `Start_in` in 1: request a multiply. Sampled on a rising edge while in IDLE or DONE.
- `Multiplicand_in32` in 32: unsigned operand A. Captured on the accepting edge only.
- `Multiplier_in32` in 32: unsigned operand B. Captured on the accepting edge only.
- `Product_out64` out 64: registered result A×B. Updated only on the completing edge, then held.
- `Busy_out` out 1: high while iterations are in progress.
- `Done_out` out 1: one-cycle pulse when `Product_out64` has just been updated.

## Operation
- Internal registers:
  - `mcand[31:0]`
  - accumulator `{c, hi[31:0], lo[31:0]}` (65 bits)
  - iteration counter `cnt[4:0]`
  - state ∈ {IDLE, RUN, DONE}
- Adder hookup: `A_in32 = hi`, `B_in32 = lo[0] ? mcand : 32'h0`, `Carry_in = 0`. The adder's `Sum_out32`/`Carry_out` are the new `{c, hi}`.
- IDLE:
  - Outputs: `Busy_out = 0`, `Done_out = 0`.
  - On `Start_in = 1`: load `mcand ← Multiplicand_in32`, `hi ← 0`, `c ← 0`, `lo ← Multiplier_in32`, `cnt ← 0`, then go to RUN.
- RUN:
  - Output: `Busy_out = 1`.
  - Each edge: `{c, hi, lo} ← {Carry_out, Sum_out32, lo} >> 1` and `cnt ← cnt + 1`.
  - On the edge where `cnt == 31`, perform the final iteration, load `Product_out64 ← {hi, lo}` from the post-shift value, and go to DONE.
  - `Start_in` is ignored in RUN. Operand inputs may change freely without effect.
- DONE:
  - Outputs: `Done_out = 1`, `Busy_out = 0`, for exactly one cycle.
  - Next edge: if `Start_in = 1`, accept new operands exactly as in IDLE and go to RUN (back-to-back operation). Otherwise go to IDLE.
  - `Product_out64` keeps its value in both cases.
- Arithmetic:
  - Unsigned only; the full 64-bit product is exact for all inputs.
  - The adder carry is retained in `c` and shifted into `hi[31]`, so no bit is lost.
  - Zero operands still take the full 32 iterations (no early termination).
- Reset (asynchronous, any state, including mid-RUN): state ← IDLE, all internal registers ← 0, `Product_out64 ← 0`, `Busy_out ← 0`, `Done_out ← 0`. An in-flight operation is discarded; the next `Start_in` after reset release starts cleanly.
- `Product_out64` never shows partial products.

## Timing
- Start edge t0 (accepted):
  - `Busy_out` rises after t0.
  - Iterations occur on edges t1…t32.
  - After t32: `Busy_out = 0`, `Done_out = 1`, `Product_out64` valid.
  - After t33: `Done_out = 0`.
- Latency: start edge to `Done_out` high is 32 cycles. Back-to-back throughput is one result per 33 cycles.
- All outputs are registered or decoded directly from state. No combinational path from inputs to outputs.
- The adder path (`hi` → ripple through 32 bits → `{c, hi}`) is the critical path and must close in one clock period.

## Test plan
- Reset, then `Start_in` with A=3, B=5 → `Busy_out` high for 32 cycles, `Done_out` pulses once, `Product_out64 = 64'h0000_0000_0000_000F`.
- A=32'hFFFF_FFFF, B=32'hFFFF_FFFF → `Product_out64 = 64'hFFFF_FFFE_0000_0001` (exercises adder carry into `c`).
- A=32'h1234_5678, B=0 and then A=0, B=32'hDEAD_BEEF → product 0 both times. Each still takes 32 cycles; the previous result holds until the next `Done_out`.
- During RUN of A=7, B=9, pulse `Start_in` with A=1, B=1 and toggle the operand inputs → result is 63, and no second `Done_out` follows.
- Hold `Start_in` high through DONE after A=2, B=3 with the next operands A=10, B=10 → `Done_out` pulse with 6, `Busy_out` rises the next cycle, and 32 cycles later `Done_out` pulses with 100.
- Assert `Reset_n_in` low at iteration 15 of A=32'h8000_0000, B=2 → all outputs 0 immediately, no `Done_out`. A fresh start after release yields `64'h0000_0001_0000_0000`.
